// File: rtl/gestor_botones.sv
// Turns debounced button levels into short/long press events with one pending slot per
// button and a round-robin shared valid/ready port. Optional auto-repeat: GESTOR_AUTOREPEAT_EN.
module gestor_botones #(
  parameter  int unsigned N_BOT    = 4,
  parameter  int unsigned LONG_CNT = 50000,
  parameter  int unsigned REP_CNT  = 25000,
  localparam int unsigned IDW      = (N_BOT > 1) ? $clog2(N_BOT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BOT-1:0] boton_db,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDW-1:0]   evt_id,
  output logic             evt_long,
  output logic [N_BOT-1:0] ovf,
  input  logic             ovf_clr
);

  localparam int unsigned CW = $clog2(LONG_CNT + 1);
`ifdef GESTOR_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(REP_CNT + 1);
`endif

  // Reject illegal configurations at elaboration time.
  if (N_BOT < 1 || N_BOT > 8 || LONG_CNT < 2 || REP_CNT < 2) begin : g_bad_params
    $error("gestor_botones: illegal parameter set");
  end

  logic [N_BOT-1:0] w_evt;
  logic [N_BOT-1:0] w_evt_long;
  logic [N_BOT-1:0] w_pend;
  logic [N_BOT-1:0] w_kind;
  logic [N_BOT-1:0] w_gnt;
  logic [N_BOT-1:0] w_ovf;

  logic             r_evt_valid;
  logic [IDW-1:0]   r_evt_id;
  logic             r_evt_long;
  logic [IDW-1:0]   r_rr;

  logic             w_load;
  logic             w_found;
  logic [IDW-1:0]   w_sel;
  logic [IDW-1:0]   w_scan;
  logic [IDW-1:0]   w_rr_next;

  for (genvar gi = 0; gi < N_BOT; gi++) begin : g_bot
    logic          r_prev;
    logic [CW-1:0] r_cnt;
    logic          r_long_sent;
    logic          r_pend;
    logic          r_kind;
    logic          r_ovf;
    logic          w_rel;
    logic          w_long_hit;
    logic          w_rep_hit;
    logic          w_drop;

    assign w_rel      = r_prev && !boton_db[gi];
    assign w_long_hit = boton_db[gi] && (r_cnt == CW'(LONG_CNT - 1));

`ifdef GESTOR_AUTOREPEAT_EN
    logic [RW-1:0] r_rep;

    assign w_rep_hit = boton_db[gi] && r_long_sent && (r_rep == RW'(REP_CNT - 1));

    // Repeat period counter, restarted by every long emission while held.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rep <= '0;
      end else if (!boton_db[gi] || w_long_hit || w_rep_hit) begin
        r_rep <= '0;
      end else if (r_long_sent) begin
        r_rep <= r_rep + RW'(1);
      end
    end
`else
    assign w_rep_hit = 1'b0;
`endif

    // Events raised while the button is held are long; the release event is short.
    assign w_evt[gi]      = w_long_hit || w_rep_hit || (w_rel && !r_long_sent);
    assign w_evt_long[gi] = boton_db[gi];
    assign w_drop         = w_evt[gi] && r_pend && !w_gnt[gi];

    assign w_pend[gi] = r_pend;
    assign w_kind[gi] = r_kind;
    assign w_ovf[gi]  = r_ovf;

    // Level history, saturating held counter and one-long-per-press flag.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_prev      <= 1'b0;
        r_cnt       <= '0;
        r_long_sent <= 1'b0;
      end else begin
        r_prev <= boton_db[gi];
        if (!boton_db[gi]) begin
          r_cnt       <= '0;
          r_long_sent <= 1'b0;
        end else begin
          if (r_cnt != CW'(LONG_CNT)) begin
            r_cnt <= r_cnt + CW'(1);
          end
          if (w_long_hit) begin
            r_long_sent <= 1'b1;
          end
        end
      end
    end

    // Pending slot: a grant in the same cycle frees room for the new event.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_pend <= 1'b0;
        r_kind <= 1'b0;
      end else if (w_evt[gi]) begin
        if (!r_pend || w_gnt[gi]) begin
          r_pend <= 1'b1;
          r_kind <= w_evt_long[gi];
        end
      end else if (w_gnt[gi]) begin
        r_pend <= 1'b0;
      end
    end

    // Sticky drop flag; clear wins over a simultaneous set.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_ovf <= 1'b0;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Round-robin search for the first pending slot at or after r_rr.
  always_comb begin
    w_load  = !r_evt_valid || evt_ready;
    w_found = 1'b0;
    w_sel   = '0;
    w_scan  = '0;
    for (int k = 0; k < int'(N_BOT); k++) begin
      w_scan = IDW'((int'(r_rr) + k) % int'(N_BOT));
      if (!w_found && w_pend[w_scan]) begin
        w_found = 1'b1;
        w_sel   = w_scan;
      end
    end
    w_gnt     = (w_load && w_found) ? (N_BOT'(1) << w_sel) : '0;
    w_rr_next = (w_sel == IDW'(N_BOT - 1)) ? '0 : (w_sel + IDW'(1));
  end

  // Output event register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evt_valid <= 1'b0;
      r_evt_id    <= '0;
      r_evt_long  <= 1'b0;
      r_rr        <= '0;
    end else if (w_load) begin
      if (w_found) begin
        r_evt_valid <= 1'b1;
        r_evt_id    <= w_sel;
        r_evt_long  <= w_kind[w_sel];
        r_rr        <= w_rr_next;
      end else begin
        r_evt_valid <= 1'b0;
      end
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_id    = r_evt_id;
  assign evt_long  = r_evt_long;
  assign ovf       = w_ovf;

endmodule
